mmix_operand_fetch: RTL and testbench
=====================================

// Module: mmix_operand_fetch
// PURPOSE
//  Operand-fetch stage sitting directly upstream of al_unit: takes a decoded instruction's Y/Z fields,
//  reads the register file (one sync read port) or forms immediates, and presents y/z with y_valid/z_valid.
//  Forwards al_unit's regwe/regwa/regwd writeback so back-to-back dependent ops see fresh data.
//  Holds operands stable until al_unit signals done, then releases and becomes ready for the next op.
// PARAMETERS
//  DATA_W   64  operand / register width
//  RADDR_W  8   register number width (256 GPRs)
// PORTS
//  clk        in   1        clock; all logic on posedge
//  reset_n    in   1        reset, synchronous, active-low
//  start      in   1        request new fetch; accepted when start && ready
//  y_field    in   8        Y field (register number or immediate)
//  z_field    in   8        Z field (register number or immediate)
//  y_imm      in   1        Y is 8-bit immediate (zero-extended)
//  z_imm      in   1        Z is 8-bit immediate (zero-extended)
//  wyde_imm   in   1        16-bit immediate: z={48'b0,y_field,z_field}, y=0; overrides y_imm/z_imm
//  ready      out  1        state==IDLE
//  rf_re      out  1        register-file read enable
//  rf_ra      out  RADDR_W  register-file read address
//  rf_rd      in   DATA_W   read data, valid the cycle after rf_re (RF is read-before-write)
//  wb_we      in   1        writeback enable (from al_unit regwe)
//  wb_wa      in   RADDR_W  writeback address (regwa)
//  wb_wd      in   DATA_W   writeback data (regwd)
//  release_op in   1        consumer done; frees held operands
//  y, z       out  DATA_W   operands to al_unit (registered)
//  y_valid    out  1        y holds fetched operand
//  z_valid    out  1        z holds fetched operand
// BEHAVIOUR
//  Reset (reset_n=0 at posedge, any state): state<=IDLE; y,z<=0; y_valid,z_valid<=0; fwd flags<=0.
//   rf_re is combinational from state, so 0 once IDLE. Mid-fetch reset discards the op entirely.
//  FSM states: IDLE, RD_Y, RD_Z, CAP_Z, HOLD. rf_re=1 only in RD_Y (ra=y_q) and RD_Z when !z_imm_q (ra=z_q).
//  Accept cycle N (IDLE, start=1): latch fields/flags into *_q.
//   wyde_imm: z<=imm16, y<=0, both valid at N+1; ->HOLD.
//   y_imm&&z_imm: y,z<=zero-ext fields, both valid at N+1; ->HOLD.
//   y_imm only: y<=zero-ext, y_valid at N+1; ->RD_Z.   Otherwise ->RD_Y.
//  RD_Y (N+1): issue Y read; ->RD_Z.
//  RD_Z (N+2): y<=fwd(rf_rd), y_valid<=1 (visible N+3) unless y already valid;
//   z_imm: z<=zero-ext, z_valid<=1, ->HOLD; else issue Z read, ->CAP_Z.
//  CAP_Z: z<=fwd(rf_rd), z_valid<=1; ->HOLD. Reg-reg latency: y_valid N+3, z_valid N+4.
//  Forwarding, per operand: if wb_we && wb_wa==addr in the read-issue cycle, latch wb_wd into a fwd reg
//   and use it at capture; if wb_we && wb_wa==addr in the capture cycle, use wb_wd (latest wins).
//   Immediates are never forwarded. Same-cycle writes matching both Y and Z addr forward to both.
//  HOLD: y/z/valids stable, no forwarding updates. release_op=1 -> valids<=0, ->IDLE (ready next cycle).
//  start while !ready is ignored (not queued); upstream holds start until accepted.
//  release_op outside HOLD is ignored. y_field==z_field is legal (two reads, same value).
// TESTING
//  RF[3]=3,RF[5]=5; start y=3,z=5 at N -> rf_ra=3@N+1, 5@N+2; y=3,y_valid@N+3; z=5,z_valid@N+4.
//  start y=3, z_field=0xFF z_imm=1 -> z=0xFF; y=RF[3]; both valid @N+3; only one rf_re pulse.
//  wyde_imm y=0x12 z=0x34 -> z=0x1234, y=0, both valid @N+1, rf_re never asserted.
//  reg-reg y=3,z=5; wb_we wa=3 wd=0xDEAD @N+1, wa=5 wd=0xBEEF @N+3 -> y=0xDEAD, z=0xBEEF.
//  In HOLD: start pulses ignored, values stable; release_op=1 -> valids 0 next cycle, ready=1.
//  reset_n=0 @N+2 of reg-reg fetch -> next cycle IDLE, y=z=0, valids 0, rf_re 0; new op fetches cleanly.

Source files
------------

// File: rtl/mmix_operand_fetch_if.sv
// Operand-fetch bus: upstream instruction fields, register-file read port,
// al_unit writeback snoop and operand outputs.
interface mmix_operand_fetch_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned RADDR_W = 8
);
  logic               start;
  logic [7:0]         y_field;
  logic [7:0]         z_field;
  logic               y_imm;
  logic               z_imm;
  logic               wyde_imm;
  logic               ready;
  logic               rf_re;
  logic [RADDR_W-1:0] rf_ra;
  logic [DATA_W-1:0]  rf_rd;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_wa;
  logic [DATA_W-1:0]  wb_wd;
  logic               release_op;
  logic [DATA_W-1:0]  y;
  logic [DATA_W-1:0]  z;
  logic               y_valid;
  logic               z_valid;

  modport master (
    output start, y_field, z_field, y_imm, z_imm, wyde_imm, rf_rd,
           wb_we, wb_wa, wb_wd, release_op,
    input  ready, rf_re, rf_ra, y, z, y_valid, z_valid
  );

  modport slave (
    input  start, y_field, z_field, y_imm, z_imm, wyde_imm, rf_rd,
           wb_we, wb_wa, wb_wd, release_op,
    output ready, rf_re, rf_ra, y, z, y_valid, z_valid
  );
endinterface

// File: rtl/mmix_operand_fetch.sv
// Operand-fetch stage feeding al_unit: reads Y/Z from a sync-read register file or
// forms immediates, snoops writeback for forwarding, and holds operands until released.
module mmix_operand_fetch #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned RADDR_W = 8
) (
  input logic                 i_clk,
  input logic                 i_reset_n,
  mmix_operand_fetch_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRdY, StRdZ, StCapZ, StHold} state_e;

  state_e             r_state;
  logic [7:0]         r_y_q;
  logic [7:0]         r_z_q;
  logic               r_z_imm_q;
  logic [DATA_W-1:0]  r_y;
  logic [DATA_W-1:0]  r_z;
  logic               r_y_valid;
  logic               r_z_valid;
  logic               r_y_fwd_vld;
  logic               r_z_fwd_vld;
  logic [DATA_W-1:0]  r_y_fwd;
  logic [DATA_W-1:0]  r_z_fwd;

  logic               w_y_hit;
  logic               w_z_hit;
  logic [DATA_W-1:0]  w_y_cap;
  logic [DATA_W-1:0]  w_z_cap;

  assign w_y_hit = bus.wb_we && (bus.wb_wa == RADDR_W'(r_y_q));
  assign w_z_hit = bus.wb_we && (bus.wb_wa == RADDR_W'(r_z_q));

  // A write in the capture cycle is newer than anything seen at read issue.
  assign w_y_cap = w_y_hit ? bus.wb_wd : (r_y_fwd_vld ? r_y_fwd : bus.rf_rd);
  assign w_z_cap = w_z_hit ? bus.wb_wd : (r_z_fwd_vld ? r_z_fwd : bus.rf_rd);

  assign bus.ready   = (r_state == StIdle);
  assign bus.rf_re   = (r_state == StRdY) || ((r_state == StRdZ) && !r_z_imm_q);
  assign bus.rf_ra   = (r_state == StRdY) ? RADDR_W'(r_y_q) : RADDR_W'(r_z_q);
  assign bus.y       = r_y;
  assign bus.z       = r_z;
  assign bus.y_valid = r_y_valid;
  assign bus.z_valid = r_z_valid;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_y_q       <= '0;
      r_z_q       <= '0;
      r_z_imm_q   <= 1'b0;
      r_y         <= '0;
      r_z         <= '0;
      r_y_valid   <= 1'b0;
      r_z_valid   <= 1'b0;
      r_y_fwd_vld <= 1'b0;
      r_z_fwd_vld <= 1'b0;
      r_y_fwd     <= '0;
      r_z_fwd     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_y_q       <= bus.y_field;
            r_z_q       <= bus.z_field;
            r_z_imm_q   <= bus.z_imm;
            r_y_fwd_vld <= 1'b0;
            r_z_fwd_vld <= 1'b0;
            if (bus.wyde_imm) begin
              r_y       <= '0;
              r_z       <= {{(DATA_W-16){1'b0}}, bus.y_field, bus.z_field};
              r_y_valid <= 1'b1;
              r_z_valid <= 1'b1;
              r_state   <= StHold;
            end else if (bus.y_imm && bus.z_imm) begin
              r_y       <= {{(DATA_W-8){1'b0}}, bus.y_field};
              r_z       <= {{(DATA_W-8){1'b0}}, bus.z_field};
              r_y_valid <= 1'b1;
              r_z_valid <= 1'b1;
              r_state   <= StHold;
            end else if (bus.y_imm) begin
              r_y       <= {{(DATA_W-8){1'b0}}, bus.y_field};
              r_y_valid <= 1'b1;
              r_state   <= StRdZ;
            end else begin
              r_state   <= StRdY;
            end
          end
        end
        StRdY: begin
          if (w_y_hit) begin
            r_y_fwd     <= bus.wb_wd;
            r_y_fwd_vld <= 1'b1;
          end
          r_state <= StRdZ;
        end
        StRdZ: begin
          if (!r_y_valid) begin
            r_y       <= w_y_cap;
            r_y_valid <= 1'b1;
          end
          if (r_z_imm_q) begin
            r_z       <= {{(DATA_W-8){1'b0}}, r_z_q};
            r_z_valid <= 1'b1;
            r_state   <= StHold;
          end else begin
            if (w_z_hit) begin
              r_z_fwd     <= bus.wb_wd;
              r_z_fwd_vld <= 1'b1;
            end
            r_state <= StCapZ;
          end
        end
        StCapZ: begin
          r_z       <= w_z_cap;
          r_z_valid <= 1'b1;
          r_state   <= StHold;
        end
        StHold: begin
          if (bus.release_op) begin
            r_y_valid <= 1'b0;
            r_z_valid <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mmix_operand_fetch.sv
// Directed bench for mmix_operand_fetch with a read-before-write register-file model.
module tb_mmix_operand_fetch;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_err;
  int   re_cnt;
  int   re_base;

  logic [63:0] rf [256];

  mmix_operand_fetch_if #(.DATA_W(64), .RADDR_W(8)) bus ();

  mmix_operand_fetch #(.DATA_W(64), .RADDR_W(8)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: entry i holds i after reset; read sees pre-write contents.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) rf[i] <= 64'(i);
      bus.rf_rd <= '0;
      re_cnt    <= 0;
    end else begin
      if (bus.rf_re) begin
        bus.rf_rd <= rf[bus.rf_ra];
        re_cnt    <= re_cnt + 1;
      end
      if (bus.wb_we) rf[bus.wb_wa] <= bus.wb_wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic release_hold();
    bus.release_op = 1'b1;
    tick();
    bus.release_op = 1'b0;
  endtask

  task automatic issue(input logic [7:0] yf, input logic [7:0] zf,
                       input logic yi, input logic zi, input logic wi);
    bus.y_field  = yf;
    bus.z_field  = zf;
    bus.y_imm    = yi;
    bus.z_imm    = zi;
    bus.wyde_imm = wi;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.y_imm    = 1'b0;
    bus.z_imm    = 1'b0;
    bus.wyde_imm = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.y_field    = '0;
    bus.z_field    = '0;
    bus.y_imm      = 1'b0;
    bus.z_imm      = 1'b0;
    bus.wyde_imm   = 1'b0;
    bus.wb_we      = 1'b0;
    bus.wb_wa      = '0;
    bus.wb_wd      = '0;
    bus.release_op = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus.ready, 1);
    chk("rst_y", bus.y, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_valids", {bus.y_valid, bus.z_valid}, 0);
    chk("rst_rf_re", bus.rf_re, 0);
    reset_n = 1'b1;
    tick();

    // Reg-reg fetch: now at N+1 after issue
    issue(8'd3, 8'd5, 0, 0, 0);
    chk("rr_n1_re", bus.rf_re, 1);
    chk("rr_n1_ra", bus.rf_ra, 3);
    chk("rr_n1_ready", bus.ready, 0);
    tick();
    chk("rr_n2_re", bus.rf_re, 1);
    chk("rr_n2_ra", bus.rf_ra, 5);
    chk("rr_n2_yv", bus.y_valid, 0);
    tick();
    chk("rr_n3_y", bus.y, 3);
    chk("rr_n3_valids", {bus.y_valid, bus.z_valid}, 2'b10);
    chk("rr_n3_re", bus.rf_re, 0);
    tick();
    chk("rr_n4_z", bus.z, 5);
    chk("rr_n4_valids", {bus.y_valid, bus.z_valid}, 2'b11);
    // start during HOLD must be ignored
    bus.start   = 1'b1;
    bus.y_field = 8'd9;
    tick();
    bus.start   = 1'b0;
    chk("hold_y", bus.y, 3);
    chk("hold_z", bus.z, 5);
    chk("hold_ready", bus.ready, 0);
    release_hold();
    chk("rel_valids", {bus.y_valid, bus.z_valid}, 0);
    chk("rel_ready", bus.ready, 1);

    // Reg Y, immediate Z
    re_base = re_cnt;
    issue(8'd3, 8'hFF, 0, 1, 0);
    chk("zi_n1_ra", bus.rf_ra, 3);
    tick();
    chk("zi_n2_re", bus.rf_re, 0);
    tick();
    chk("zi_n3_y", bus.y, 3);
    chk("zi_n3_z", bus.z, 64'hFF);
    chk("zi_n3_valids", {bus.y_valid, bus.z_valid}, 2'b11);
    chk("zi_pulses", 64'(re_cnt - re_base), 1);
    release_hold();

    // Wyde immediate
    re_base = re_cnt;
    issue(8'h12, 8'h34, 1, 0, 1);
    chk("wy_y", bus.y, 0);
    chk("wy_z", bus.z, 64'h1234);
    chk("wy_valids", {bus.y_valid, bus.z_valid}, 2'b11);
    chk("wy_re", bus.rf_re, 0);
    tick();
    chk("wy_pulses", 64'(re_cnt - re_base), 0);
    release_hold();

    // Forwarding: Y via latched fwd at read issue, Z direct at capture
    issue(8'd3, 8'd5, 0, 0, 0);
    bus.wb_we = 1'b1; bus.wb_wa = 8'd3; bus.wb_wd = 64'hDEAD;
    tick();
    bus.wb_we = 1'b0;
    tick();
    bus.wb_we = 1'b1; bus.wb_wa = 8'd5; bus.wb_wd = 64'hBEEF;
    tick();
    bus.wb_we = 1'b0;
    chk("fwd_y", bus.y, 64'hDEAD);
    chk("fwd_z", bus.z, 64'hBEEF);
    chk("fwd_valids", {bus.y_valid, bus.z_valid}, 2'b11);
    release_hold();

    // Reset mid-fetch at N+2
    issue(8'd3, 8'd5, 0, 0, 0);
    tick();
    reset_n = 1'b0;
    tick();
    chk("mrst_ready", bus.ready, 1);
    chk("mrst_y", bus.y, 0);
    chk("mrst_z", bus.z, 0);
    chk("mrst_valids", {bus.y_valid, bus.z_valid}, 0);
    chk("mrst_re", bus.rf_re, 0);
    reset_n = 1'b1;
    tick();
    issue(8'd3, 8'd5, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("post_y", bus.y, 3);
    chk("post_z", bus.z, 5);
    chk("post_valids", {bus.y_valid, bus.z_valid}, 2'b11);
    release_hold();

    // Immediate Y, register Z
    issue(8'h07, 8'd5, 1, 0, 0);
    chk("yi_n1_y", bus.y, 7);
    chk("yi_n1_yv", bus.y_valid, 1);
    chk("yi_n1_ra", bus.rf_ra, 5);
    tick();
    chk("yi_n2_zv", bus.z_valid, 0);
    tick();
    chk("yi_n3_z", bus.z, 5);
    chk("yi_n3_zv", bus.z_valid, 1);
    release_hold();

    // Same register for Y and Z; write at N+2 reaches both operands
    issue(8'd3, 8'd3, 0, 0, 0);
    tick();
    bus.wb_we = 1'b1; bus.wb_wa = 8'd3; bus.wb_wd = 64'h77;
    tick();
    bus.wb_we = 1'b0;
    chk("same_y", bus.y, 64'h77);
    tick();
    chk("same_z", bus.z, 64'h77);
    release_hold();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
